id_redirect_ctrl: RTL and testbench

//  ID-stage control feeding the fetch stage: decodes IF_ID and drives PC_IF_ID_Write, select_PC_next, targets, status.

---
 rtl/id_redirect_ctrl.sv | 123 ++++++++++++
 tb/tb_id_redirect_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/id_redirect_ctrl.sv
// id_redirect_ctrl: ID-stage branch/jump resolution, hazard stall, undefined-op exception, irq take and EPC.
module id_redirect_ctrl #(
    parameter int IRQ_SYNC_STAGES = 2,
    parameter bit EXC_ON_UNDEF    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] IF_ID,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        ID_EX_RegWrite,
    input  logic        ID_EX_MemRead,
    input  logic [4:0]  ID_EX_dst,
    input  logic        EX_MEM_MemRead,
    input  logic [4:0]  EX_MEM_dst,
    input  logic        irq,
    output logic        PC_IF_ID_Write,
    output logic [2:0]  select_PC_next,
    output logic [31:0] branch_target,
    output logic [31:0] jump_target,
    output logic [31:0] jr_target,
    output logic [1:0]  status,
    output logic        flush_ID,
    output logic [31:0] epc
);
    logic [IRQ_SYNC_STAGES:0] sync_q;
    logic        pend_q, pend_d, kill_q, kill_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] pc, ins, off;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt;
    logic signed [31:0] rsv;
    logic bubble, kernel, rise, is_r, is_beq, is_bne, is_blez, is_bgtz, is_rgm, is_br, is_j, is_jr;
    logic defined, taken, use_rs, use_rt, load_use, hit_rs, hit_rt, br_haz;
    logic stall, redirect, undef, exc, intr;

    assign pc      = IF_ID[63:32];
    assign ins     = IF_ID[31:0];
    assign op      = ins[31:26];
    assign rs      = ins[25:21];
    assign rt      = ins[20:16];
    assign funct   = ins[5:0];
    assign rsv     = rs_data;
    assign off     = {{14{ins[15]}}, ins[15:0], 2'b00};
    assign bubble  = kill_q | (IF_ID == 64'd0);
    assign kernel  = pc[31];
    assign rise    = sync_q[IRQ_SYNC_STAGES-1] & ~sync_q[IRQ_SYNC_STAGES];
    assign is_r    = op == 6'h00;
    assign is_beq  = op == 6'h04;
    assign is_bne  = op == 6'h05;
    assign is_blez = op == 6'h06;
    assign is_bgtz = op == 6'h07;
    assign is_rgm  = (op == 6'h01) & (rt[4:1] == 4'd0);
    assign is_br   = is_beq | is_bne | is_blez | is_bgtz | is_rgm;
    assign is_j    = (op == 6'h02) | (op == 6'h03);
    assign is_jr   = is_r & ((funct == 6'h08) | (funct == 6'h09));
    assign defined = ((op <= 6'h0f) & ~((op == 6'h01) & (rt[4:1] != 4'd0))) | (op == 6'h23) | (op == 6'h2b);
    assign taken   = (is_beq & (rs_data == rt_data)) | (is_bne & (rs_data != rt_data)) |
                     (is_blez & (rsv <= 0)) | (is_bgtz & (rsv > 0)) |
                     (is_rgm & (rt[0] ? (rsv >= 0) : (rsv < 0)));
    assign use_rs  = ~is_j;
    assign use_rt  = is_r | is_beq | is_bne | (op == 6'h2b);
    assign load_use = ID_EX_MemRead & (ID_EX_dst != 5'd0) &
                      ((use_rs & (ID_EX_dst == rs)) | (use_rt & (ID_EX_dst == rt)));
    // Branch operands are compared here in ID, so any in-flight producer not yet forwardable stalls.
    assign hit_rs  = (rs != 5'd0) & ((ID_EX_RegWrite & (ID_EX_dst == rs)) | (EX_MEM_MemRead & (EX_MEM_dst == rs)));
    assign hit_rt  = (rt != 5'd0) & ((ID_EX_RegWrite & (ID_EX_dst == rt)) | (EX_MEM_MemRead & (EX_MEM_dst == rt)));
    assign br_haz  = ((is_br | is_jr) & hit_rs) | ((is_beq | is_bne) & hit_rt);
    assign stall    = ~bubble & (load_use | br_haz);
    assign redirect = ~bubble & (taken | is_j | is_jr);
    assign undef    = ~bubble & ~defined;
    assign exc      = undef & EXC_ON_UNDEF & ~kernel;
    assign intr     = ~bubble & pend_q & ~kernel;

    assign branch_target = {pc[31], pc[30:0] + off[30:0]};
    assign jump_target   = {pc[31:28], ins[25:0], 2'b00};
    assign jr_target     = rs_data;
    assign epc           = epc_q;

    always_comb begin
        PC_IF_ID_Write = 1'b1;
        flush_ID       = 1'b0;
        select_PC_next = 3'b000;
        status         = 2'b00;
        kill_d         = 1'b0;
        epc_d          = epc_q;
        pend_d         = pend_q | rise;
        if (kill_q) begin
            flush_ID = 1'b1;
        end else if (stall) begin
            PC_IF_ID_Write = 1'b0;
            flush_ID       = 1'b1;
        end else if (redirect) begin
            select_PC_next = taken ? 3'b100 : is_j ? 3'b010 : 3'b001;
        end else if (exc) begin
            status   = 2'b01;
            flush_ID = 1'b1;
            epc_d    = pc - 32'd4;
            kill_d   = 1'b1;
        end else if (intr) begin
            status = 2'b10;
            epc_d  = pc;
            kill_d = 1'b1;
            pend_d = rise;
        end else begin
            flush_ID = undef;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            pend_q <= 1'b0;
            kill_q <= 1'b0;
            epc_q  <= 32'd0;
        end else begin
            sync_q <= {sync_q[IRQ_SYNC_STAGES-1:0], irq};
            pend_q <= pend_d;
            kill_q <= kill_d;
            epc_q  <= epc_d;
        end
    end
endmodule

// File: tb/tb_id_redirect_ctrl.sv
// tb_id_redirect_ctrl: scoreboard bench for id_redirect_ctrl redirect, stall, trap and irq behaviour.
module tb_id_redirect_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [63:0] IF_ID = '0;
    logic [31:0] rs_data = '0, rt_data = '0;
    logic        ID_EX_RegWrite = 1'b0, ID_EX_MemRead = 1'b0, EX_MEM_MemRead = 1'b0, irq = 1'b0;
    logic [4:0]  ID_EX_dst = '0, EX_MEM_dst = '0;
    logic        PC_IF_ID_Write, flush_ID;
    logic [2:0]  select_PC_next;
    logic [31:0] branch_target, jump_target, jr_target, epc;
    logic [1:0]  status;
    int n_cmp = 0, n_err = 0;

    typedef struct packed {logic w; logic f; logic [2:0] s; logic [1:0] st;} exp_t;
    exp_t sb[$];

    localparam logic [31:0] ADD = 32'h0022_2020, BEQ3 = 32'h1022_0003, UND = 32'hFC00_0000;

    id_redirect_ctrl dut (
        .clk(clk), .rst_n(rst_n), .IF_ID(IF_ID), .rs_data(rs_data), .rt_data(rt_data),
        .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_dst(ID_EX_dst),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_dst(EX_MEM_dst), .irq(irq),
        .PC_IF_ID_Write(PC_IF_ID_Write), .select_PC_next(select_PC_next),
        .branch_target(branch_target), .jump_target(jump_target), .jr_target(jr_target),
        .status(status), .flush_ID(flush_ID), .epc(epc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic [31:0] p, input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        IF_ID   = {p, i};
        rs_data = a;
        rt_data = b;
    endtask

    task automatic haz(input logic rw, input logic mr, input logic [4:0] d, input logic mm, input logic [4:0] md);
        ID_EX_RegWrite = rw;
        ID_EX_MemRead  = mr;
        ID_EX_dst      = d;
        EX_MEM_MemRead = mm;
        EX_MEM_dst     = md;
    endtask

    task automatic cyc(input string tag, input logic w, input logic f, input logic [2:0] s, input logic [1:0] st);
        exp_t e;
        sb.push_back('{w, f, s, st});
        @(negedge clk);
        e = sb.pop_front();
        chk({tag, ".write"}, {31'd0, PC_IF_ID_Write}, {31'd0, e.w});
        chk({tag, ".flush"}, {31'd0, flush_ID}, {31'd0, e.f});
        chk({tag, ".sel"}, {29'd0, select_PC_next}, {29'd0, e.s});
        chk({tag, ".status"}, {30'd0, status}, {30'd0, e.st});
        @(posedge clk);
        #1;
    endtask

    task automatic take_irq(input string tag);
        int i;
        for (i = 0; i < 8; i++) begin
            @(negedge clk);
            if (status == 2'b10) break;
            chk({tag, ".pre"}, {30'd0, status}, 32'd0);
            @(posedge clk);
            #1;
        end
        chk({tag, ".status"}, {30'd0, status}, 32'd2);
        chk({tag, ".flush"}, {31'd0, flush_ID}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(negedge clk);
        chk("rst.epc", epc, 32'd0);
        chk("rst.write", {31'd0, PC_IF_ID_Write}, 32'd1);
        chk("rst.sel", {29'd0, select_PC_next}, 32'd0);
        chk("rst.status", {30'd0, status}, 32'd0);
        chk("rst.flush", {31'd0, flush_ID}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("bubble", 1, 0, 3'b000, 2'b00);
        // branches and jumps
        drv(32'h8000_0008, BEQ3, 32'd5, 32'd5);
        #1 chk("t1.btgt", branch_target, 32'h8000_0014);
        cyc("t1.taken", 1, 0, 3'b100, 2'b00);
        drv(32'h8000_0008, BEQ3, 32'd5, 32'd6);
        cyc("t1.ntaken", 1, 0, 3'b000, 2'b00);
        drv(32'h8000_0008, 32'h1422_0003, 32'd5, 32'd6);
        cyc("bne", 1, 0, 3'b100, 2'b00);
        drv(32'h0000_0100, 32'h1022_FFFF, 32'd1, 32'd1);
        #1 chk("bneg.btgt", branch_target, 32'h0000_00FC);
        drv(32'hFFFF_FFFC, 32'h1022_0001, 32'd1, 32'd1);
        #1 chk("bwrap.btgt", branch_target, 32'h8000_0000);
        drv(32'h0000_0100, 32'h1820_0000, 32'd0, 32'd0);
        cyc("blez0", 1, 0, 3'b100, 2'b00);
        drv(32'h0000_0100, 32'h1C20_0000, 32'h8000_0000, 32'd0);
        cyc("bgtzneg", 1, 0, 3'b000, 2'b00);
        drv(32'h0000_0100, 32'h0420_0000, 32'hFFFF_FFFF, 32'd0);
        cyc("bltz", 1, 0, 3'b100, 2'b00);
        drv(32'h0000_0100, 32'h0421_0000, 32'd0, 32'd0);
        cyc("bgez0", 1, 0, 3'b100, 2'b00);
        drv(32'h1000_0004, 32'h0800_0010, 32'd0, 32'd0);
        #1 chk("j.jtgt", jump_target, 32'h1000_0040);
        cyc("j", 1, 0, 3'b010, 2'b00);
        drv(32'h1000_0004, 32'h0C00_0010, 32'd0, 32'd0);
        cyc("jal", 1, 0, 3'b010, 2'b00);
        drv(32'h1000_0004, 32'h00A0_0008, 32'h1234_5678, 32'd0);
        #1 chk("jr.tgt", jr_target, 32'h1234_5678);
        cyc("jr", 1, 0, 3'b001, 2'b00);
        drv(32'h1000_0004, 32'h00A0_0009, 32'h1234_5678, 32'd0);
        cyc("jalr", 1, 0, 3'b001, 2'b00);
        // hazards
        drv(32'h0000_0100, 32'h1060_0001, 32'd7, 32'd7);
        haz(1, 1, 5'd3, 0, 5'd0);
        cyc("t2.c1", 0, 1, 3'b000, 2'b00);
        haz(0, 0, 5'd0, 1, 5'd3);
        cyc("t2.c2", 0, 1, 3'b000, 2'b00);
        haz(0, 0, 5'd0, 0, 5'd0);
        cyc("t2.c3", 1, 0, 3'b100, 2'b00);
        drv(32'h0000_0100, BEQ3, 32'd1, 32'd1);
        haz(1, 0, 5'd1, 0, 5'd0);
        cyc("alu.br", 0, 1, 3'b000, 2'b00);
        drv(32'h0000_0100, ADD, 32'd1, 32'd1);
        cyc("alu.add", 1, 0, 3'b000, 2'b00);
        haz(1, 1, 5'd2, 0, 5'd0);
        cyc("lu.rt", 0, 1, 3'b000, 2'b00);
        haz(1, 1, 5'd0, 0, 5'd0);
        cyc("lu.r0", 1, 0, 3'b000, 2'b00);
        haz(0, 0, 5'd0, 0, 5'd0);
        // undefined opcodes
        drv(32'h0000_0104, UND, 32'd0, 32'd0);
        cyc("t3.exc", 1, 1, 3'b000, 2'b01);
        chk("t3.epc", epc, 32'h0000_0100);
        drv(32'h0000_0108, ADD, 32'd0, 32'd0);
        cyc("t3.kill", 1, 1, 3'b000, 2'b00);
        cyc("t3.after", 1, 0, 3'b000, 2'b00);
        drv(32'h8000_0104, UND, 32'd0, 32'd0);
        cyc("undk", 1, 1, 3'b000, 2'b00);
        drv(32'h0000_0204, 32'h0422_0000, 32'd0, 32'd0);
        cyc("rgm2", 1, 1, 3'b000, 2'b01);
        chk("rgm2.epc", epc, 32'h0000_0200);
        drv(32'h0000_0200, ADD, 32'd0, 32'd0);
        cyc("rgm2.kill", 1, 1, 3'b000, 2'b00);
        // interrupts
        irq = 1'b1;
        cyc("t4.add", 1, 0, 3'b000, 2'b00);
        irq = 1'b0;
        take_irq("t4");
        chk("t4.epc", epc, 32'h0000_0200);
        cyc("t4.kill", 1, 1, 3'b000, 2'b00);
        cyc("t4.after", 1, 0, 3'b000, 2'b00);
        drv(32'h1000_0004, 32'h0800_0010, 32'd0, 32'd0);
        irq = 1'b1;
        cyc("t5.j0", 1, 0, 3'b010, 2'b00);
        irq = 1'b0;
        for (int i = 0; i < 5; i++) cyc("t5.j", 1, 0, 3'b010, 2'b00);
        drv(32'h0, 32'h0, 32'd0, 32'd0);
        cyc("t5.bub", 1, 0, 3'b000, 2'b00);
        drv(32'h0000_0300, ADD, 32'd0, 32'd0);
        cyc("t5.int", 1, 0, 3'b000, 2'b10);
        chk("t5.epc", epc, 32'h0000_0300);
        cyc("t5.kill", 1, 1, 3'b000, 2'b00);
        drv(32'h8000_0200, ADD, 32'd0, 32'd0);
        irq = 1'b1;
        cyc("t6.k0", 1, 0, 3'b000, 2'b00);
        irq = 1'b0;
        for (int i = 0; i < 5; i++) cyc("t6.k", 1, 0, 3'b000, 2'b00);
        drv(32'h0000_0504, UND, 32'd0, 32'd0);
        cyc("xi.exc", 1, 1, 3'b000, 2'b01);
        chk("xi.epc", epc, 32'h0000_0500);
        cyc("xi.kill", 1, 1, 3'b000, 2'b00);
        drv(32'h0000_0400, ADD, 32'd0, 32'd0);
        cyc("t6.int", 1, 0, 3'b000, 2'b10);
        chk("t6.epc", epc, 32'h0000_0400);
        cyc("t6.kill", 1, 1, 3'b000, 2'b00);
        // reset while kill is active and an irq is pending
        drv(32'h8000_0200, ADD, 32'd0, 32'd0);
        irq = 1'b1;
        cyc("rs.k0", 1, 0, 3'b000, 2'b00);
        irq = 1'b0;
        for (int i = 0; i < 5; i++) cyc("rs.k", 1, 0, 3'b000, 2'b00);
        drv(32'h0000_0704, UND, 32'd0, 32'd0);
        cyc("rs.exc", 1, 1, 3'b000, 2'b01);
        drv(32'h0000_0708, ADD, 32'd0, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rs.flush", {31'd0, flush_ID}, 32'd0);
        chk("rs.epc", epc, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) cyc("rs.noirq", 1, 0, 3'b000, 2'b00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
